// File: rtl/captura_operandos_ascii.sv
// Captures an ASCII expression "XX+YY=" (or terminated by CR) from a character
// stream and presents both operands as tens/units ASCII digit pairs.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   char_in, char_valid incoming ASCII character and its one-cycle strobe
//   char_ready          block can accept a character (low while holding a result)
//   AD_A, AU_A          operand A tens/units ASCII digits
//   AD_B, AU_B          operand B tens/units ASCII digits
//   operands_valid      operand outputs hold a complete expression
//   operands_ack        downstream consumed the operands
//   error               one-cycle pulse when an illegal character is rejected
module captura_operandos_ascii #(
    parameter logic [6:0] SEP_CHAR = 7'h2B,
    parameter logic [6:0] END_CHAR = 7'h3D,
    parameter logic [6:0] ESC_CHAR = 7'h1B
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [6:0] AD_A,
    output logic [6:0] AU_A,
    output logic [6:0] AD_B,
    output logic [6:0] AU_B,
    output logic       operands_valid,
    input  logic       operands_ack,
    output logic       error
);

    localparam int unsigned CHAR_W = 7;
    localparam logic [CHAR_W-1:0] ASCII_ZERO  = 7'h30;
    localparam logic [CHAR_W-1:0] ASCII_NINE  = 7'h39;
    localparam logic [CHAR_W-1:0] ASCII_CR    = 7'h0D;
    localparam logic [CHAR_W-1:0] ASCII_SPACE = 7'h20;

    typedef enum logic [2:0] {
        S_A1, S_A2, S_SEP, S_B1, S_B2, S_END, S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [CHAR_W-1:0] hold, hold_nx;
    logic [CHAR_W-1:0] ad_a_nx, au_a_nx, ad_b_nx, au_b_nx;
    logic              valid_nx, ready_nx, error_nx;
    logic              accept, is_digit, is_term, do_clear, do_err;

    assign accept   = char_valid && char_ready;
    assign is_digit = (char_in >= ASCII_ZERO) && (char_in <= ASCII_NINE);
    assign is_term  = (char_in == END_CHAR) || (char_in == ASCII_CR);

    // Next-state and next-output computation for all registered outputs.
    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        ad_a_nx  = AD_A;
        au_a_nx  = AU_A;
        ad_b_nx  = AD_B;
        au_b_nx  = AU_B;
        do_clear = 1'b0;
        do_err   = 1'b0;

        if (state == S_DONE) begin
            // Characters are blocked here; only the ack moves us on.
            if (operands_ack) state_nx = S_A1;
        end else if (accept) begin
            if (char_in == ESC_CHAR) begin
                do_clear = 1'b1;
            end else if (char_in != ASCII_SPACE) begin
                unique case (state)
                    S_A1: begin
                        if (is_digit) begin
                            hold_nx  = char_in;
                            state_nx = S_A2;
                        end else do_err = 1'b1;
                    end
                    S_A2: begin
                        if (is_digit) begin
                            ad_a_nx  = hold;
                            au_a_nx  = char_in;
                            state_nx = S_SEP;
                        end else if (char_in == SEP_CHAR) begin
                            ad_a_nx  = ASCII_ZERO;
                            au_a_nx  = hold;
                            state_nx = S_B1;
                        end else do_err = 1'b1;
                    end
                    S_SEP: begin
                        if (char_in == SEP_CHAR) state_nx = S_B1;
                        else do_err = 1'b1;
                    end
                    S_B1: begin
                        if (is_digit) begin
                            hold_nx  = char_in;
                            state_nx = S_B2;
                        end else do_err = 1'b1;
                    end
                    S_B2: begin
                        if (is_digit) begin
                            ad_b_nx  = hold;
                            au_b_nx  = char_in;
                            state_nx = S_END;
                        end else if (is_term) begin
                            ad_b_nx  = ASCII_ZERO;
                            au_b_nx  = hold;
                            state_nx = S_DONE;
                        end else do_err = 1'b1;
                    end
                    S_END: begin
                        if (is_term) state_nx = S_DONE;
                        else do_err = 1'b1;
                    end
                    default: do_err = 1'b1;
                endcase
            end
        end

        // Error and ESC share the same clear; only error raises the pulse.
        if (do_clear || do_err) begin
            state_nx = S_A1;
            hold_nx  = ASCII_ZERO;
            ad_a_nx  = ASCII_ZERO;
            au_a_nx  = ASCII_ZERO;
            ad_b_nx  = ASCII_ZERO;
            au_b_nx  = ASCII_ZERO;
        end

        error_nx = do_err;
        valid_nx = (state_nx == S_DONE);
        ready_nx = (state_nx != S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_A1;
            hold           <= ASCII_ZERO;
            AD_A           <= ASCII_ZERO;
            AU_A           <= ASCII_ZERO;
            AD_B           <= ASCII_ZERO;
            AU_B           <= ASCII_ZERO;
            operands_valid <= 1'b0;
            char_ready     <= 1'b1;
            error          <= 1'b0;
        end else begin
            state          <= state_nx;
            hold           <= hold_nx;
            AD_A           <= ad_a_nx;
            AU_A           <= au_a_nx;
            AD_B           <= ad_b_nx;
            AU_B           <= au_b_nx;
            operands_valid <= valid_nx;
            char_ready     <= ready_nx;
            error          <= error_nx;
        end
    end

endmodule

// File: tb/tb_captura_operandos_ascii.sv
// Scoreboard bench for captura_operandos_ascii: a parser model predicts parsed
// results and rejected characters; a monitor checks what the DUT presents.
module tb_captura_operandos_ascii;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [6:0] AD_A, AU_A, AD_B, AU_B;
    logic       operands_valid;
    logic       operands_ack;
    logic       error;

    captura_operandos_ascii dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .AD_A(AD_A), .AU_A(AU_A), .AD_B(AD_B), .AU_B(AU_B),
        .operands_valid(operands_valid), .operands_ack(operands_ack), .error(error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [27:0] exp_q[$];   // {AD_A, AU_A, AD_B, AU_B}
    int          err_q[$];   // index of the character expected to be rejected
    int          char_idx = 0;
    int          last_idx = -1;

    // Parser model: digits collected per operand, plus whether '+' was seen.
    int         a_n, b_n;
    logic [6:0] a_d[2];
    logic [6:0] b_d[2];
    bit         have_sep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic bit is_dig(input logic [6:0] c);
        return (c >= 7'h30) && (c <= 7'h39);
    endfunction

    task automatic model_clear();
        a_n = 0; b_n = 0; have_sep = 0;
    endtask

    function automatic logic [13:0] operand(input int n, input logic [6:0] d0, input logic [6:0] d1);
        return (n == 2) ? {d0, d1} : {7'h30, d0};
    endfunction

    // Feed one accepted character to the model; done=1 when an expression completes.
    task automatic model_char(input logic [6:0] c, input int idx, output bit done);
        done = 0;
        if (c == 7'h1B) model_clear();
        else if (c == 7'h20) begin end
        else if (!have_sep) begin
            if (is_dig(c) && a_n < 2) begin a_d[a_n] = c; a_n++; end
            else if (c == 7'h2B && a_n >= 1) have_sep = 1;
            else begin err_q.push_back(idx); model_clear(); end
        end else begin
            if (is_dig(c) && b_n < 2) begin b_d[b_n] = c; b_n++; end
            else if ((c == 7'h3D || c == 7'h0D) && b_n >= 1) begin
                exp_q.push_back({operand(a_n, a_d[0], a_d[1]), operand(b_n, b_d[0], b_d[1])});
                model_clear();
                done = 1;
            end else begin err_q.push_back(idx); model_clear(); end
        end
    endtask

    // Monitor: compares results and error pulses against the scoreboard queues.
    logic prev_valid = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (error) begin
                chk("error_width", 32'(prev_err), 32'd0);
                if (err_q.size() == 0) chk("unexpected_error", 32'(last_idx), 32'hFFFFFFFF);
                else chk("error_char_idx", 32'(last_idx), 32'(err_q.pop_front()));
                chk("clear_outputs", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, {4{7'h30}}});
            end
            if (operands_valid && !prev_valid) begin
                if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else chk("operands", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, exp_q.pop_front()});
            end
        end
        prev_valid = operands_valid;
        prev_err   = error;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Consume a held result; optionally strobe a character together with ack.
    task automatic handshake(input bit strobe_with_ack);
        logic [27:0] snap;
        int hold_cycles;
        chk("valid_after_term", 32'(operands_valid), 32'd1);
        snap = {AD_A, AU_A, AD_B, AU_B};
        hold_cycles = $urandom_range(1, 3);
        for (int i = 0; i < hold_cycles; i++) begin
            chk("ready_low_in_done", 32'(char_ready), 32'd0);
            char_in = 7'h35; char_valid = 1'b1;   // must be ignored
            tick();
            char_valid = 1'b0;
            chk("valid_held", 32'(operands_valid), 32'd1);
        end
        chk("outputs_frozen", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, snap});
        operands_ack = 1'b1;
        if (strobe_with_ack) begin char_in = 7'h39; char_valid = 1'b1; end
        tick();
        operands_ack = 1'b0; char_valid = 1'b0;
        chk("valid_after_ack", 32'(operands_valid), 32'd0);
        chk("ready_after_ack", 32'(char_ready), 32'd1);
        chk("outputs_after_ack", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, snap});
    endtask

    task automatic send_char(input logic [6:0] c);
        bit done;
        char_in = c; char_valid = 1'b1;
        last_idx = char_idx;
        model_char(c, char_idx, done);
        char_idx++;
        tick();
        char_valid = 1'b0;
        if (done) handshake(1'b0);
        else repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(7'(s[i]));
    endtask

    task automatic wait_drain();
        int budget = 20;
        while ((exp_q.size() != 0 || err_q.size() != 0) && budget > 0) begin tick(); budget--; end
        chk("scoreboard_drained", 32'(exp_q.size() + err_q.size()), 32'd0);
    endtask

    logic [6:0] junk[7];
    initial begin
        junk = '{7'h78, 7'h33, 7'h2B, 7'h3D, 7'h0D, 7'h1B, 7'h20};
        model_clear();
        rst_n = 1'b0; char_in = 7'h00; char_valid = 1'b0; operands_ack = 1'b0;
        #12;
        chk("rst_outputs", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, {4{7'h30}}});
        chk("rst_flags", {29'h0, operands_valid, error, char_ready}, 32'b001);
        @(negedge clk); rst_n = 1'b1;
        tick();

        send_str("12+34=");
        send_str({"7+9", 8'h0D});
        send_str("123");
        send_str("05+10=");
        send_str("4 5+x");
        chk("ab_after_err_x", {18'h0, AD_A, AU_A}, {18'h0, 7'h30, 7'h30});
        send_str({"8+", 8'h1B});
        chk("esc_clear", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, {4{7'h30}}});
        chk("esc_no_error", 32'(error), 32'd0);

        // Character strobed together with ack must not be captured.
        send_char(7'h31); send_char(7'h2B); send_char(7'h32);
        char_in = 7'h3D; char_valid = 1'b1; begin bit d; last_idx = char_idx; model_char(7'h3D, char_idx, d); end
        char_idx++;
        tick(); char_valid = 1'b0;
        handshake(1'b1);
        send_char(7'h2B);   // no digit captured, so '+' is rejected

        // Asynchronous reset mid-expression.
        send_str("5+6");
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {4'h0, AD_A, AU_A, AD_B, AU_B}, {4'h0, {4{7'h30}}});
        chk("async_rst_flags", {29'h0, operands_valid, error, char_ready}, 32'b001);
        model_clear();
        @(negedge clk); rst_n = 1'b1;
        tick();
        send_str("99+99=");
        wait_drain();

        // Randomized expressions with occasional illegal or control characters.
        for (int e = 0; e < 60; e++) begin
            int an = $urandom_range(1, 2);
            int bn = $urandom_range(1, 2);
            logic [6:0] s[$];
            for (int i = 0; i < an; i++) s.push_back(7'(7'h30 + $urandom_range(0, 9)));
            s.push_back(7'h2B);
            for (int i = 0; i < bn; i++) s.push_back(7'(7'h30 + $urandom_range(0, 9)));
            s.push_back($urandom_range(0, 1) ? 7'h3D : 7'h0D);
            for (int i = 0; i < s.size(); i++) begin
                if ($urandom_range(0, 9) == 0) send_char(junk[$urandom_range(0, 6)]);
                send_char(s[i]);
            end
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/captura_operandos_ascii.md
Name: captura_operandos_ascii

Overview:
- Upstream stage of the ASCII-to-binary converter. Receives a stream of 7-bit ASCII characters, one per valid strobe, from the keyboard/UART front end.
- Parses an expression of the form "XX+YY=" or "XX+YY<CR>", where each operand is 1 or 2 decimal digits.
- Presents each operand as a tens/units ASCII digit pair (AD/AU) that feeds the ASCII-to-binary converter directly.
- Holds the parsed result under a valid/ack handshake until the downstream adder path consumes it.

Parameters:
- SEP_CHAR, 7'h2B, operand separator ('+').
- END_CHAR, 7'h3D, expression terminator ('='). 7'h0D (CR) is always accepted as an alternate terminator.
- ESC_CHAR, 7'h1B, abort/clear character.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- char_in  input  7  ASCII character, qualified by char_valid.
- char_valid  input  1  single-cycle strobe; the character is accepted when char_valid && char_ready.
- char_ready  output  1  block can accept a character.
- AD_A  output  7  operand A tens digit, ASCII.
- AU_A  output  7  operand A units digit, ASCII.
- AD_B  output  7  operand B tens digit, ASCII.
- AU_B  output  7  operand B units digit, ASCII.
- operands_valid  output  1  AD_A/AU_A/AD_B/AU_B hold a complete parsed expression.
- operands_ack  input  1  downstream consumed the operands.
- error  output  1  one-cycle pulse when an illegal character is rejected.

Behaviour:
- Reset (async assert, sync release):
  - state = S_A1.
  - AD_A = AU_A = AD_B = AU_B = 7'h30.
  - digit hold register = 7'h30.
  - operands_valid = 0, error = 0, char_ready = 1.
- Digit: char_in in 7'h30..7'h39. Space (7'h20) is accepted and ignored in every state except S_DONE.
- char_ready = 1 in every state except S_DONE.
- States and transitions (on an accepted character):
  - S_A1:
    - digit -> hold = char, go to S_A2.
    - any other character -> error.
  - S_A2:
    - digit -> AD_A = hold, AU_A = char, go to S_SEP.
    - SEP_CHAR -> AD_A = 7'h30, AU_A = hold, go to S_B1.
    - any other character -> error.
  - S_SEP:
    - SEP_CHAR -> go to S_B1.
    - anything else, including a third digit -> error.
  - S_B1:
    - digit -> hold = char, go to S_B2.
    - any other character -> error.
  - S_B2:
    - digit -> AD_B = hold, AU_B = char, go to S_END.
    - END_CHAR or CR -> AD_B = 7'h30, AU_B = hold, go to S_DONE.
    - any other character -> error.
  - S_END:
    - END_CHAR or CR -> go to S_DONE.
    - anything else -> error.
  - S_DONE:
    - operands_valid = 1; outputs frozen; char_valid ignored.
    - operands_ack = 1 -> go to S_A1. operands_valid reads 0 from the next cycle.
- Latency: operands_valid rises on the clock edge that accepts the terminator, i.e. it is visible in the cycle after the terminator strobe.
- Error action:
  - error = 1 for exactly one cycle.
  - All operand outputs and hold return to 7'h30.
  - state = S_A1.
  - The offending character is discarded.
- ESC_CHAR in any state except S_DONE: same clear as an error, but error stays 0.
- operands_ack outside S_DONE: ignored.
- A character strobe in the same cycle as operands_ack in S_DONE: not accepted, because char_ready = 0 that cycle.
- Operand outputs change only on the transitions listed above. Outside S_DONE they may hold partial values; downstream uses them only while operands_valid = 1.
- Reset asserted mid-expression: immediate return to the reset values; the partial expression is lost.

Test Plan:
- Stream "12+34=" with 1 idle cycle between strobes -> AD_A=7'h31, AU_A=7'h32, AD_B=7'h33, AU_B=7'h34. operands_valid=1 from the cycle after '=' and held until ack; char_ready=0 meanwhile.
- Stream "7+9" followed by CR -> AD_A=7'h30, AU_A=7'h37, AD_B=7'h30, AU_B=7'h39, valid=1. Pulse ack -> valid=0 next cycle and char_ready=1.
- Stream "123" -> error pulses exactly 1 cycle on '3'. All outputs return to 7'h30. Following "05+10=" parses to 30/35/31/30.
- Stream "4 5+x" -> space ignored, A = 34/35; error on 'x'. Stream "8+" then ESC -> no error, state S_A1, outputs 7'h30.
- In S_DONE, drive char_valid with '9' and ack in the same cycle -> '9' not accepted, outputs unchanged until ack, then back in S_A1 with no digit captured.
- Assert rst_n=0 asynchronously after "5+6" -> outputs 7'h30, valid=0, error=0 immediately. Release, then "99+99=" -> all four outputs 7'h39.
